// File: rtl/phy_stim_pkg.sv
// rtl/phy_stim_pkg.sv - shared encodings and defaults for the PHY lane stimulus generator
package phy_stim_pkg;

  // Burst pattern selection; the unused encoding 2'd3 behaves as constant
  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  // Burst sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } stim_state_t;

  // Galois tap mask for an 8-bit maximal-length sequence
  localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/phy_lane_word_gen.sv
// rtl/phy_lane_word_gen.sv - one lane word register with per-mode next-value logic
module phy_lane_word_gen
  import phy_stim_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter int              LANES     = 4,
  parameter int              LANE_IDX  = 0,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEF_LFSR_TAPS)
) (
  input  logic             clk32f,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] word
);

  // Lane offset keeps lanes distinct; stride makes INCR a byte-striped stream
  localparam logic [WIDTH-1:0] LANE_OFF    = WIDTH'(LANE_IDX);
  localparam logic [WIDTH-1:0] LANE_STRIDE = WIDTH'(LANES);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] first_val;
  logic [WIDTH-1:0] step_val;

  // Word 0 and the successor of the current word for the latched mode
  always_comb begin
    start_val = seed + LANE_OFF;
    first_val = start_val;
    // An all-zero LFSR state would lock up, so it is nudged to 1
    if (mode == MODE_LFSR && start_val == '0) begin
      first_val = ONE;
    end
    case (mode)
      MODE_CONST: step_val = start_val;
      MODE_INCR:  step_val = word + LANE_STRIDE;
      MODE_LFSR:  step_val = (word >> 1) ^ (word[0] ? LFSR_TAPS : '0);
      default:    step_val = start_val;
    endcase
  end

  // Lane word register: clear wins over load, load wins over step
  always_ff @(posedge clk32f or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word <= first_val;
    end else if (step) begin
      word <= step_val;
    end
  end

endmodule

// File: rtl/phy_stim_gen.sv
// rtl/phy_stim_gen.sv - divided-strobe lane traffic generator with start/busy/done handshake
module phy_stim_gen
  import phy_stim_pkg::*;
#(
  parameter int               LANES     = 4,
  parameter int               WIDTH     = 8,
  parameter int               DIV_LOG2  = 5,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEF_LFSR_TAPS)
) (
  input  logic                   clk32f,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [LANES-1:0]       lane_en,
  input  logic [WIDTH-1:0]       seed,
  input  logic [15:0]            burst_len,
  output logic [DIV_LOG2:0]      tick,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   busy,
  output logic                   done
);

  stim_state_t          state;
  logic [DIV_LOG2-1:0]  div_cnt;
  logic                 wstb;
  logic [1:0]           lat_mode;
  logic [LANES-1:0]     lat_en;
  logic [WIDTH-1:0]     lat_seed;
  logic [15:0]          lat_len;
  logic [15:0]          wcnt;
  logic                 last_word;
  logic                 lane_load;
  logic                 lane_step;
  logic                 lane_clear;

  // Free-running divider replacing the old ripple-divided clocks
  always_ff @(posedge clk32f or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_LOG2'(1);
    end
  end

  // tick[k] fires when the low k divider bits are all ones (every 2^k cycles)
  assign tick[0] = 1'b1;
  for (genvar k = 1; k <= DIV_LOG2; k++) begin : g_tick
    assign tick[k] = &div_cnt[k-1:0];
  end

  assign wstb = tick[DIV_LOG2];

  // Lane controls derived from the sequencer position at each word strobe
  always_comb begin
    last_word  = (wcnt == lat_len);
    lane_load  = (state == ST_ARM) && wstb;
    lane_step  = (state == ST_RUN) && wstb && !last_word;
    lane_clear = (state == ST_RUN) && wstb && last_word;
  end

  // Burst sequencer; inputs are captured once so mid-burst changes have no effect
  always_ff @(posedge clk32f or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_mode  <= MODE_CONST;
      lat_en    <= '0;
      lat_seed  <= '0;
      lat_len   <= '0;
      wcnt      <= '0;
      valid_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            lat_mode <= mode;
            lat_en   <= lane_en;
            lat_seed <= seed;
            lat_len  <= burst_len;
            busy     <= 1'b1;
            state    <= (burst_len == 16'd0) ? ST_DONE : ST_ARM;
          end
        end
        ST_ARM: begin
          // Align the first word to the divider so every word gets a full period
          if (wstb) begin
            valid_out <= lat_en;
            wcnt      <= 16'd1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (wstb) begin
            if (last_word) begin
              valid_out <= '0;
              state     <= ST_DONE;
            end else begin
              // wcnt stops at lat_len, so it cannot wrap even for 65535
              wcnt <= wcnt + 16'd1;
            end
          end
        end
        ST_DONE: begin
          // done lands one cycle after valid drops, as busy is released
          done  <= 1'b1;
          busy  <= 1'b0;
          wcnt  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // One word register per lane, all stepped together on the word strobe
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_lane_word_gen #(
      .WIDTH     (WIDTH),
      .LANES     (LANES),
      .LANE_IDX  (i),
      .LFSR_TAPS (LFSR_TAPS)
    ) u_lane (
      .clk32f (clk32f),
      .rst    (rst),
      .load   (lane_load),
      .step   (lane_step),
      .clear  (lane_clear),
      .mode   (lat_mode),
      .seed   (lat_seed),
      .word   (data_out[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_phy_stim_gen.sv
// tb/tb_phy_stim_gen.sv - directed scoreboard bench for phy_stim_gen
module tb_phy_stim_gen;

  logic        clk32f = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  lane_en;
  logic [7:0]  seed;
  logic [15:0] burst_len;
  logic [5:0]  tick;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic        busy;
  logic        done;
  logic [2:0]  tick2;
  logic [31:0] data2;
  logic [3:0]  valid2;
  logic        busy2;
  logic        done2;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk32f = ~clk32f;

  phy_stim_gen dut (
    .clk32f    (clk32f),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .lane_en   (lane_en),
    .seed      (seed),
    .burst_len (burst_len),
    .tick      (tick),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done)
  );

  phy_stim_gen #(.DIV_LOG2(2)) dut2 (
    .clk32f    (clk32f),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .lane_en   (lane_en),
    .seed      (seed),
    .burst_len (burst_len),
    .tick      (tick2),
    .data_out  (data2),
    .valid_out (valid2),
    .busy      (busy2),
    .done      (done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk32f);
    #1;
  endtask

  // Reference word n of a burst, all four lanes packed lane0 in the low byte
  function automatic logic [31:0] model_word(input logic [1:0] m, input logic [7:0] s, input int n);
    logic [31:0] r;
    logic [7:0]  x;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (m == 2'd1) begin
        x = s + 8'(n * 4 + i);
      end else if (m == 2'd2) begin
        x = s + 8'(i);
        if (x == 8'h00) x = 8'h01;
        for (int j = 0; j < n; j++) x = {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
      end else begin
        x = s + 8'(i);
      end
      r[i*8 +: 8] = x;
    end
    return r;
  endfunction

  task automatic run_burst(input logic [1:0] m, input logic [3:0] en, input logic [7:0] s,
                           input logic [15:0] len, input bit disturb);
    logic [31:0] cur;
    bit          seen;
    bit          bad_hold;
    bit          bad_valid;
    mode = m; lane_en = en; seed = s; burst_len = len; start = 1'b1;
    for (int n = 0; n < int'(len); n++) exp_q.push_back(model_word(m, s, n));
    cyc();
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      cyc();
      if (valid_out != 4'h0) seen = 1'b1;
    end
    chk("valid_rise", seen, 1);
    if (!seen) begin
      exp_q.delete();
      return;
    end
    bad_hold = 1'b0; bad_valid = 1'b0; cur = '0;
    for (int t = 0; t < int'(len) * 32; t++) begin
      if (t > 0) cyc();
      if (disturb && t == 10) begin
        start = 1'b1; seed = 8'h55; mode = 2'd0; lane_en = 4'h0;
      end
      if (disturb && t == 14) start = 1'b0;
      if (t % 32 == 0) begin
        cur = exp_q.pop_front();
        chk($sformatf("word%0d", t / 32), data_out, cur);
      end else if (data_out !== cur) begin
        bad_hold = 1'b1;
      end
      if (valid_out !== en) bad_valid = 1'b1;
    end
    chk("word_hold", bad_hold, 0);
    chk("valid_span", bad_valid, 0);
    cyc();
    chk("valid_fall", valid_out, 0);
    chk("data_clear", data_out, 0);
    chk("done_not_yet", done, 0);
    cyc();
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    cyc();
    chk("done_single", done, 0);
  endtask

  initial begin
    logic [31:0] cur;
    bit          seen;
    bit          bad;
    int          vcnt;

    rst = 1'b1; start = 1'b0; mode = 2'd0; lane_en = 4'h0; seed = 8'h00; burst_len = 16'd0;
    repeat (10) cyc();
    chk("rst_tick", tick, 6'h01);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    repeat (30) cyc();
    chk("tick5_c30", tick[5], 0);
    cyc();
    chk("tick_c31", tick, 6'h3F);
    cyc();
    chk("tick5_c32", tick[5], 0);
    repeat (31) cyc();
    chk("tick5_c63", tick[5], 1);

    run_burst(2'd1, 4'hF, 8'hFC, 16'd3, 1'b0);
    run_burst(2'd2, 4'b0101, 8'h00, 16'd3, 1'b0);

    // Zero-length burst goes straight to completion
    mode = 2'd0; lane_en = 4'hF; seed = 8'h33; burst_len = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zl_busy", busy, 1);
    chk("zl_done0", done, 0);
    chk("zl_valid0", valid_out, 0);
    cyc();
    chk("zl_busy_end", busy, 0);
    chk("zl_done1", done, 1);
    chk("zl_valid1", valid_out, 0);
    cyc();
    chk("zl_done_single", done, 0);

    run_burst(2'd1, 4'hF, 8'h20, 16'd2, 1'b1);

    // Reset in the middle of word 2
    mode = 2'd1; lane_en = 4'hF; seed = 8'h40; burst_len = 16'd4; start = 1'b1;
    cur = model_word(2'd1, 8'h40, 2);
    cyc();
    start = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      cyc();
      if (valid_out != 4'h0) seen = 1'b1;
    end
    chk("mr_valid_rise", seen, 1);
    repeat (64) cyc();
    chk("mr_word2", data_out, cur);
    #2 rst = 1'b1;
    #1;
    chk("mr_data", data_out, 0);
    chk("mr_valid", valid_out, 0);
    chk("mr_busy", busy, 0);
    chk("mr_tick", tick, 6'h01);
    @(posedge clk32f);
    #1 rst = 1'b0;
    repeat (5) cyc();
    chk("mr_idle_busy", busy, 0);
    chk("mr_idle_valid", valid_out, 0);

    // Short divider: CONST words at one word every 4 cycles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mode = 2'd0; lane_en = 4'hF; seed = 8'h10; burst_len = 16'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      cyc();
      if (valid2 != 4'h0) seen = 1'b1;
    end
    chk("d2_valid_rise", seen, 1);
    chk("d2_word", data2, 32'h13121110);
    vcnt = 0; bad = 1'b0;
    for (int w = 0; w < 20 && valid2 != 4'h0; w++) begin
      vcnt++;
      if (data2 !== 32'h13121110) bad = 1'b1;
      cyc();
    end
    chk("d2_valid_cycles", vcnt, 8);
    chk("d2_hold", bad, 0);
    chk("d2_data_clear", data2, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
